// File: rtl/serial_count_unit_pkg.sv
// Shared types for the serial count unit: FSM states, internal op encoding,
// and the issue/exception structures seen on its ports.
package serial_count_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned CNT_W         = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef enum logic [1:0] {OP_CPOP, OP_CLZ, OP_CTZ, OP_NONE} cnt_op_e;

  typedef enum logic [7:0] {ADD, SUB, ANDL, ORL, CLZ, CTZ, CPOP} fu_op;

  typedef struct packed {
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  function automatic cnt_op_e map_op(fu_op op);
    case (op)
      CPOP:    return OP_CPOP;
      CLZ:     return OP_CLZ;
      CTZ:     return OP_CTZ;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/serial_count_unit_if.sv
// Issue-side valid/ready plus writeback slot of the serial count unit.
interface serial_count_unit_if
  import serial_count_pkg::*;
#(
  parameter int unsigned XLEN       = serial_count_pkg::XLEN,
  parameter int unsigned TRANS_ID_W = serial_count_pkg::TRANS_ID_BITS
) ();

  logic                  valid;
  logic                  ready;
  fu_data_t              fu_data;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [TRANS_ID_W-1:0] wb_trans_id;
  logic [XLEN-1:0]       wb_result;
  exception_t            wb_ex;

  modport master (
    output valid, fu_data, wb_ready,
    input  ready, wb_valid, wb_trans_id, wb_result, wb_ex
  );

  modport slave (
    input  valid, fu_data, wb_ready,
    output ready, wb_valid, wb_trans_id, wb_result, wb_ex
  );

endinterface

// File: rtl/serial_count_unit_datapath.sv
// Bit-serial datapath: shift register, running count, bit index and stop detect.
module serial_count_datapath
  import serial_count_pkg::*;
#(
  parameter int unsigned XLEN  = serial_count_pkg::XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  cnt_op_e          op_i,
  input  logic [XLEN-1:0]  operand_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam int unsigned IDX_W = $clog2(XLEN);

  logic [XLEN-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cnt_op_e          op_q, op_d;
  logic             stop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      op_q    <= OP_NONE;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    idx_d   = idx_q;
    op_d    = op_q;
    stop    = 1'b0;
    if (load_i) begin
      shreg_d = operand_i;
      count_d = '0;
      idx_d   = '0;
      op_d    = op_i;
    end else if (step_i) begin
      idx_d = idx_q + IDX_W'(1);
      case (op_q)
        OP_CPOP: begin
          shreg_d = shreg_q >> 1;
          count_d = count_q + CNT_W'(shreg_q[0]);
        end
        OP_CTZ: begin
          shreg_d = shreg_q >> 1;
          if (shreg_q[0]) stop = 1'b1;
          else            count_d = count_q + CNT_W'(1);
        end
        OP_CLZ: begin
          shreg_d = shreg_q << 1;
          if (shreg_q[XLEN-1]) stop = 1'b1;
          else                 count_d = count_q + CNT_W'(1);
        end
        default: stop = 1'b1;
      endcase
    end
  end

  // Last examined bit is at idx XLEN-1, which also bounds the zero-operand case.
  assign done_o  = step_i && (stop || (idx_q == IDX_W'(XLEN - 1)));
  assign count_o = count_q;

endmodule

// File: rtl/serial_count_unit.sv
// Serial CPOP/CLZ/CTZ functional unit: IDLE/BUSY/DONE control around the
// bit-serial datapath, returning the count on a writeback slot.
module serial_count_unit
  import serial_count_pkg::*;
#(
  parameter int unsigned XLEN       = serial_count_pkg::XLEN,
  parameter int unsigned TRANS_ID_W = serial_count_pkg::TRANS_ID_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  serial_count_unit_if.slave  fu
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  state_e                state_q, state_d;
  logic [TRANS_ID_W-1:0] trans_id_q, trans_id_d;
  logic                  accept, step, dp_done;
  cnt_op_e               op_sel;
  logic [CNT_W-1:0]      count;
  logic                  unused_fields;

  assign op_sel        = map_op(fu.fu_data.operation);
  assign unused_fields = ^{fu.fu_data.operand_b, fu.fu_data.imm};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      trans_id_q <= '0;
    end else begin
      state_q    <= state_d;
      trans_id_q <= trans_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trans_id_d = trans_id_q;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fu.valid && !flush_i) begin
          accept     = 1'b1;
          trans_id_d = fu.fu_data.trans_id;
          state_d    = (op_sel == OP_NONE) ? DONE : BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (dp_done) state_d = DONE;
      end
      DONE: begin
        if (fu.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  serial_count_datapath #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .step_i    (step),
    .op_i      (op_sel),
    .operand_i (fu.fu_data.operand_a),
    .count_o   (count),
    .done_o    (dp_done)
  );

  assign fu.ready       = (state_q == IDLE);
  assign fu.wb_valid    = (state_q == DONE);
  assign fu.wb_trans_id = trans_id_q;
  assign fu.wb_result   = {{(XLEN - CNT_W){1'b0}}, count};
  assign fu.wb_ex       = '0;

endmodule

// File: tb/tb_serial_count_unit.sv
// Directed bench for serial_count_unit with immediate-assertion checks.
module tb_serial_count_unit;
  import serial_count_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_count_unit_if #(.XLEN(32), .TRANS_ID_W(3)) bus ();

  serial_count_unit #(.XLEN(32), .TRANS_ID_W(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .fu      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the op for exactly one edge; caller must be 1 time unit after an edge.
  task automatic issue(input fu_op op, input logic [31:0] a, input logic [2:0] tid);
    bus.valid              = 1'b1;
    bus.fu_data.operation  = op;
    bus.fu_data.operand_a  = a;
    bus.fu_data.operand_b  = 32'hDEAD_BEEF;
    bus.fu_data.imm        = 32'h1234_5678;
    bus.fu_data.trans_id   = tid;
    tick();
    bus.valid = 1'b0;
  endtask

  // k = cycle offset from the accept edge at which wb_valid is first seen.
  task automatic wait_wb(output int k, output bit rdy_seen);
    k = 1;
    rdy_seen = 1'b0;
    while (!bus.wb_valid && k < 200) begin
      if (bus.ready) rdy_seen = 1'b1;
      tick();
      k++;
    end
  endtask

  task automatic run_op(input string tag, input fu_op op, input logic [31:0] a,
                        input logic [2:0] tid, input int exp_res, input int exp_n);
    int k;
    bit rdy_seen;
    issue(op, a, tid);
    wait_wb(k, rdy_seen);
    chk({tag, "_latency"}, 64'(k), 64'(exp_n + 1));
    chk({tag, "_ready_low"}, 64'(rdy_seen), 64'd0);
    chk({tag, "_result"}, 64'(bus.wb_result), 64'(exp_res));
    chk({tag, "_trans_id"}, 64'(bus.wb_trans_id), 64'(tid));
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int  k;
    bit  rdy_seen;
    bit  seen;

    bus.valid   = 1'b0;
    bus.wb_ready = 1'b0;
    bus.fu_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_trans_id", 64'(bus.wb_trans_id), 64'd0);
    chk("rst_result", 64'(bus.wb_result), 64'd0);
    chk("rst_ex", 64'(bus.wb_ex != '0), 64'd0);
    rst = 1'b0;
    tick();

    run_op("cpop_f0f0", CPOP, 32'hF0F0_0001, 3'd3, 9, 32);
    run_op("clz_1e16", CLZ, 32'h0001_0000, 3'd1, 15, 16);
    run_op("ctz_msb", CTZ, 32'h8000_0000, 3'd2, 31, 32);
    run_op("clz_zero", CLZ, 32'h0, 3'd4, 32, 32);
    run_op("ctz_zero", CTZ, 32'h0, 3'd5, 32, 32);
    run_op("ctz_one", CTZ, 32'h1, 3'd6, 0, 1);
    run_op("clz_msb", CLZ, 32'h8000_0000, 3'd7, 0, 1);
    run_op("unsupported", ADD, 32'hFFFF_FFFF, 3'd1, 0, 0);

    // Backpressure in DONE
    issue(CPOP, 32'h0000_00FF, 3'd5);
    wait_wb(k, rdy_seen);
    chk("bp_latency", 64'(k), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("bp_result", 64'(bus.wb_result), 64'd8);
      chk("bp_trans_id", 64'(bus.wb_trans_id), 64'd5);
      chk("bp_ready", 64'(bus.ready), 64'd0);
      chk("bp_ex", 64'(bus.wb_ex != '0), 64'd0);
      tick();
    end
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("bp_ready_after", 64'(bus.ready), 64'd1);
    chk("bp_valid_after", 64'(bus.wb_valid), 64'd0);

    // Flush at the tenth BUSY cycle
    issue(CPOP, 32'hFFFF_FFFF, 3'd6);
    repeat (9) tick();
    chk("fl_busy", 64'(bus.ready), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ready", 64'(bus.ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wb_valid) seen = 1'b1;
      tick();
    end
    chk("fl_no_wb", 64'(seen), 64'd0);
    run_op("fl_cpop3", CPOP, 32'h0000_0003, 3'd2, 2, 32);

    // Reset asserted mid-BUSY
    issue(CTZ, 32'h0, 3'd7);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mrst_ready", 64'(bus.ready), 64'd1);
    chk("mrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mrst_trans_id", 64'(bus.wb_trans_id), 64'd0);
    chk("mrst_result", 64'(bus.wb_result), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // valid together with flush in IDLE is not accepted
    flush = 1'b1;
    issue(CPOP, 32'h0000_0001, 3'd4);
    flush = 1'b0;
    chk("vf_ready", 64'(bus.ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wb_valid || !bus.ready) seen = 1'b1;
      tick();
    end
    chk("vf_no_accept", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
